// File: rtl/power_mode_pkg.sv
// Shared encodings for the power mode manager: power_mode values, FSM states,
// wakeup source bit positions and the state-to-mode mapping.
package power_mode_pkg;

  localparam logic [1:0] MODE_DEEPSLEEP = 2'b00;
  localparam logic [1:0] MODE_STANDBY   = 2'b01;
  localparam logic [1:0] MODE_ACTIVE    = 2'b10;

  localparam int WAKE_SRC_W = 4;
  localparam int GPIO       = 0;
  localparam int UART_RX    = 1;
  localparam int TIMER      = 2;
  localparam int CAN        = 3;

  typedef enum logic [2:0] {
    ST_ACTIVE    = 3'd0,
    ST_STANDBY   = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_DEEPSLEEP = 3'd3,
    ST_WAKE      = 3'd4
  } pm_state_e;

  function automatic logic [1:0] mode_of(input pm_state_e s);
    case (s)
      ST_ACTIVE:    mode_of = MODE_ACTIVE;
      ST_DEEPSLEEP: mode_of = MODE_DEEPSLEEP;
      ST_STANDBY,
      ST_DRAIN,
      ST_WAKE:      mode_of = MODE_STANDBY;
      default:      mode_of = MODE_ACTIVE;
    endcase
  endfunction

endpackage

// File: rtl/pm_idle_counter.sv
// Saturating idle counter with clear and a ">= threshold" hit flag;
// a zero threshold never hits.
module pm_idle_counter #(
  parameter int W = 16
) (
  input  logic         clk_master,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] th,
  output logic         hit
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_master) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign hit = (th != '0) && (cnt >= th);

endmodule

// File: rtl/power_mode_manager.sv
// Power mode sequencer feeding clock_gate_controller. POWER_MODE_STATS_EN adds
// DeepSleep entry/cycle counters; without it those outputs are tied to zero.
//   state     | meaning
//   ACTIVE    | full clocks, watching idle time and sleep_req
//   STANDBY   | reduced clocks, waiting for activity or deeper idle
//   DRAIN     | settle window before DeepSleep, abortable
//   DEEPSLEEP | clocks off until wakeup_request or force_active
//   WAKE      | fixed ramp back to ACTIVE, requests ignored
module power_mode_manager
  import power_mode_pkg::*;
#(
  parameter int IDLE_CNT_W    = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int WAKE_CYCLES   = 16
) (
  input  logic                  clk_master,
  input  logic                  rst,
  input  logic                  cim_active,
  input  logic                  uart_active,
  input  logic                  dvfs_busy,
  input  logic                  sleep_req,
  input  logic                  force_active,
  input  logic                  wakeup_request,
  input  logic [WAKE_SRC_W-1:0] wakeup_source,
  input  logic [IDLE_CNT_W-1:0] standby_idle_th,
  input  logic [IDLE_CNT_W-1:0] sleep_idle_th,
  output logic [1:0]            power_mode,
  output logic                  mode_changed,
  output logic [WAKE_SRC_W-1:0] wake_cause,
  output logic [2:0]            pm_state,
  output logic [15:0]           sleep_count,
  output logic [31:0]           sleep_cycles
);

  localparam int QW = $clog2(SETTLE_CYCLES + 1);
  localparam int RW = $clog2(WAKE_CYCLES + 1);
  localparam logic [QW-1:0] QUIET_LAST = QW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RAMP_LAST  = RW'(WAKE_CYCLES - 1);

  pm_state_e             state, state_nxt;
  logic                  bad_state;
  logic                  activity;
  logic                  idle_hit;
  logic                  idle_clr;
  logic [IDLE_CNT_W-1:0] idle_th;
  logic [QW-1:0]         quiet_cnt;
  logic [RW-1:0]         ramp_cnt;

  assign activity = cim_active | uart_active | dvfs_busy;
  assign idle_th  = (state == ST_STANDBY) ? sleep_idle_th : standby_idle_th;
  assign idle_clr = activity | (state_nxt != state);

  pm_idle_counter #(.W(IDLE_CNT_W)) u_idle (
    .clk_master (clk_master),
    .rst        (rst),
    .clr        (idle_clr),
    .inc        (~activity),
    .th         (idle_th),
    .hit        (idle_hit)
  );

  // Idle thresholds only fire on a quiet cycle; dvfs_busy holds STANDBY.
  always_comb begin
    state_nxt = state;
    bad_state = 1'b0;
    case (state)
      ST_ACTIVE: begin
        if (!force_active) begin
          if (sleep_req)                  state_nxt = ST_DRAIN;
          else if (idle_hit && !activity) state_nxt = ST_STANDBY;
        end
      end
      ST_STANDBY: begin
        if (force_active || cim_active || uart_active) state_nxt = ST_ACTIVE;
        else if (sleep_req || (idle_hit && !dvfs_busy)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (force_active || wakeup_request)           state_nxt = ST_ACTIVE;
        else if (!activity && quiet_cnt == QUIET_LAST) state_nxt = ST_DEEPSLEEP;
      end
      ST_DEEPSLEEP: begin
        if (force_active || wakeup_request) state_nxt = ST_WAKE;
      end
      ST_WAKE: begin
        if (ramp_cnt == RAMP_LAST) state_nxt = ST_ACTIVE;
      end
      default: begin
        state_nxt = ST_ACTIVE;
        bad_state = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_master) begin
    if (rst) begin
      state        <= ST_ACTIVE;
      power_mode   <= MODE_ACTIVE;
      mode_changed <= 1'b0;
      wake_cause   <= '0;
      quiet_cnt    <= '0;
      ramp_cnt     <= '0;
    end else begin
      state        <= state_nxt;
      power_mode   <= mode_of(state_nxt);
      mode_changed <= bad_state || (mode_of(state_nxt) != power_mode);
      if (state == ST_DEEPSLEEP && state_nxt == ST_WAKE)
        wake_cause <= wakeup_request ? wakeup_source : '0;
      if (state == ST_DRAIN && state_nxt == ST_DRAIN && !activity)
        quiet_cnt <= quiet_cnt + QW'(1);
      else
        quiet_cnt <= '0;
      if (state == ST_WAKE && state_nxt == ST_WAKE)
        ramp_cnt <= ramp_cnt + RW'(1);
      else
        ramp_cnt <= '0;
    end
  end

  assign pm_state = state;

`ifdef POWER_MODE_STATS_EN
  logic [15:0] sleep_count_q;
  logic [31:0] sleep_cycles_q;

  always_ff @(posedge clk_master) begin
    if (rst) begin
      sleep_count_q  <= '0;
      sleep_cycles_q <= '0;
    end else begin
      if (state != ST_DEEPSLEEP && state_nxt == ST_DEEPSLEEP && sleep_count_q != '1)
        sleep_count_q <= sleep_count_q + 16'd1;
      if (state == ST_DEEPSLEEP && sleep_cycles_q != '1)
        sleep_cycles_q <= sleep_cycles_q + 32'd1;
    end
  end

  assign sleep_count  = sleep_count_q;
  assign sleep_cycles = sleep_cycles_q;
`else
  assign sleep_count  = '0;
  assign sleep_cycles = '0;
`endif

endmodule

// File: tb/tb_power_mode_manager.sv
// Bench for power_mode_manager: directed scenarios with literal expectations,
// then random stimulus checked every cycle against a behavioural model.
module tb_power_mode_manager;

`ifdef POWER_MODE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int SETTLE = 8;
  localparam int WAKE   = 16;

  logic        clk_master;
  logic        rst;
  logic        cim_active, uart_active, dvfs_busy;
  logic        sleep_req, force_active, wakeup_request;
  logic [3:0]  wakeup_source;
  logic [15:0] standby_idle_th, sleep_idle_th;
  logic [1:0]  power_mode;
  logic        mode_changed;
  logic [3:0]  wake_cause;
  logic [2:0]  pm_state;
  logic [15:0] sleep_count;
  logic [31:0] sleep_cycles;

  int n_vec  = 0;
  int n_miss = 0;

  power_mode_manager #(
    .IDLE_CNT_W    (16),
    .SETTLE_CYCLES (SETTLE),
    .WAKE_CYCLES   (WAKE)
  ) dut (
    .clk_master      (clk_master),
    .rst             (rst),
    .cim_active      (cim_active),
    .uart_active     (uart_active),
    .dvfs_busy       (dvfs_busy),
    .sleep_req       (sleep_req),
    .force_active    (force_active),
    .wakeup_request  (wakeup_request),
    .wakeup_source   (wakeup_source),
    .standby_idle_th (standby_idle_th),
    .sleep_idle_th   (sleep_idle_th),
    .power_mode      (power_mode),
    .mode_changed    (mode_changed),
    .wake_cause      (wake_cause),
    .pm_state        (pm_state),
    .sleep_count     (sleep_count),
    .sleep_cycles    (sleep_cycles)
  );

  initial begin
    clk_master = 1'b0;
    forever #5 clk_master = ~clk_master;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk_master);
  endtask

  // Model: states named by number 0=ACTIVE 1=STANDBY 2=DRAIN 3=DEEPSLEEP 4=WAKE.
  int      mode_tab [5] = '{2, 1, 1, 0, 1};
  int      m_st, m_pm, m_mc, m_cause, m_idle, m_run, m_tin, m_sc;
  longint  m_scy;
  bit      m_valid = 1'b0;

  always @(posedge clk_master) begin : model
    int act, nx, npm;
    if (rst) begin
      m_st = 0; m_pm = 2; m_mc = 0; m_cause = 0;
      m_idle = 0; m_run = 0; m_tin = 0; m_sc = 0; m_scy = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      act = int'(cim_active | uart_active | dvfs_busy);
      nx  = m_st;
      case (m_st)
        0: if (!force_active) begin
             if (sleep_req) nx = 2;
             else if (act == 0 && standby_idle_th != 0 && m_idle >= int'(standby_idle_th)) nx = 1;
           end
        1: if (force_active || cim_active || uart_active) nx = 0;
           else if (sleep_req || (!dvfs_busy && sleep_idle_th != 0 && m_idle >= int'(sleep_idle_th))) nx = 2;
        2: if (force_active || wakeup_request) nx = 0;
           else if (act == 0 && m_run == SETTLE - 1) nx = 3;
        3: if (force_active || wakeup_request) begin
             nx = 4;
             m_cause = wakeup_request ? int'(wakeup_source) : 0;
           end
        default: if (m_tin == WAKE - 1) nx = 0;
      endcase
      if (m_st == 3 && m_scy < 64'hFFFF_FFFF) m_scy++;
      if (nx == 3 && m_st != 3 && m_sc < 65535) m_sc++;
      npm  = mode_tab[nx];
      m_mc = (npm != m_pm) ? 1 : 0;
      m_pm = npm;
      if (act != 0 || nx != m_st) m_idle = 0;
      else if (m_idle < 65535) m_idle++;
      m_run = (nx == 2 && m_st == 2 && act == 0) ? m_run + 1 : 0;
      m_tin = (nx == m_st) ? m_tin + 1 : 0;
      m_st  = nx;
    end
    #2;
    if (m_valid) begin
      chk("m_power_mode", 32'(power_mode), 32'(m_pm));
      chk("m_mode_changed", 32'(mode_changed), 32'(m_mc));
      chk("m_pm_state", 32'(pm_state), 32'(m_st));
      chk("m_wake_cause", 32'(wake_cause), 32'(m_cause));
      chk("m_sleep_count", 32'(sleep_count), STATS ? 32'(m_sc) : 32'd0);
      chk("m_sleep_cycles", sleep_cycles, STATS ? m_scy[31:0] : 32'd0);
    end
  end

  initial begin
    int d;
    rst = 1'b1;
    cim_active = 0; uart_active = 0; dvfs_busy = 0;
    sleep_req = 0; force_active = 0; wakeup_request = 0;
    wakeup_source = 4'h0; standby_idle_th = 16'd10; sleep_idle_th = 16'd0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_mode", 32'(power_mode), 32'h2);
    chk("rst_state", 32'(pm_state), 32'h0);
    chk("rst_pulse", 32'(mode_changed), 32'h0);

    // Standby after 11 quiet cycles
    repeat (10) tick();
    chk("idle_pre", 32'(power_mode), 32'h2);
    tick();
    chk("standby_mode", 32'(power_mode), 32'h1);
    chk("standby_pulse", 32'(mode_changed), 32'h1);
    tick();
    chk("pulse_one_cycle", 32'(mode_changed), 32'h0);

    // cim pulse back to Active, idle time restarts
    cim_active = 1; tick(); cim_active = 0;
    chk("cim_wake_mode", 32'(power_mode), 32'h2);
    chk("cim_wake_pulse", 32'(mode_changed), 32'h1);
    repeat (10) tick();
    chk("idle_cleared", 32'(power_mode), 32'h2);
    tick();
    chk("standby_again", 32'(power_mode), 32'h1);

    // sleep_req: 8 drain cycles then DeepSleep
    standby_idle_th = 16'd0;
    force_active = 1; tick(); force_active = 0;
    chk("force_active", 32'(pm_state), 32'h0);
    sleep_req = 1; tick(); sleep_req = 0;
    chk("drain_state", 32'(pm_state), 32'h2);
    chk("drain_pulse", 32'(mode_changed), 32'h1);
    repeat (7) tick();
    chk("drain_hold", 32'(pm_state), 32'h2);
    tick();
    chk("deepsleep_mode", 32'(power_mode), 32'h0);
    chk("deepsleep_pulse", 32'(mode_changed), 32'h1);
    chk("sleep_count_1", 32'(sleep_count), STATS ? 32'd1 : 32'd0);
    dvfs_busy = 1; sleep_req = 1;
    repeat (5) tick();
    dvfs_busy = 0; sleep_req = 0;
    chk("deepsleep_ignores", 32'(pm_state), 32'h3);

    // Wake via timer source; sleep_req ignored during ramp
    wakeup_request = 1; wakeup_source = 4'b0100; tick();
    wakeup_request = 0; wakeup_source = 4'h0;
    chk("wake_state", 32'(pm_state), 32'h4);
    chk("wake_mode", 32'(power_mode), 32'h1);
    chk("wake_cause", 32'(wake_cause), 32'h4);
    chk("sleep_cycles_6", sleep_cycles, STATS ? 32'd6 : 32'd0);
    sleep_req = 1;
    repeat (15) tick();
    chk("wake_hold", 32'(pm_state), 32'h4);
    tick();
    chk("wake_done", 32'(power_mode), 32'h2);
    tick(); sleep_req = 0;
    chk("drain_again", 32'(pm_state), 32'h2);

    // dvfs_busy at quiet_cnt=5 restarts the settle window
    repeat (5) tick();
    dvfs_busy = 1; repeat (3) tick(); dvfs_busy = 0;
    chk("dvfs_drain", 32'(pm_state), 32'h2);
    repeat (7) tick();
    chk("dvfs_drain_hold", 32'(pm_state), 32'h2);
    tick();
    chk("dvfs_deepsleep", 32'(pm_state), 32'h3);
    chk("sleep_count_2", 32'(sleep_count), STATS ? 32'd2 : 32'd0);

    // force_active wake, then reset mid-ramp
    force_active = 1; tick(); force_active = 0;
    chk("force_wake", 32'(pm_state), 32'h4);
    chk("force_cause", 32'(wake_cause), 32'h0);
    repeat (5) tick();
    rst = 1; tick(); rst = 0;
    chk("rst_mid_state", 32'(pm_state), 32'h0);
    chk("rst_mid_mode", 32'(power_mode), 32'h2);
    chk("rst_mid_pulse", 32'(mode_changed), 32'h0);
    chk("rst_mid_count", 32'(sleep_count), 32'h0);
    chk("rst_mid_cycles", sleep_cycles, 32'h0);

    // Drain abort with wakeup_request and sleep_req together
    sleep_req = 1; tick();
    chk("abort_pre", 32'(pm_state), 32'h2);
    wakeup_request = 1; tick();
    wakeup_request = 0; sleep_req = 0;
    chk("abort_state", 32'(pm_state), 32'h0);
    chk("abort_pulse", 32'(mode_changed), 32'h1);

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      d = (((i / 256) % 2) == 0) ? 4 : 32;
      cim_active     = ($urandom_range(d - 1) == 0);
      uart_active    = ($urandom_range(d - 1) == 0);
      dvfs_busy      = ($urandom_range(d - 1) == 0);
      sleep_req      = ($urandom_range(15) == 0);
      force_active   = ($urandom_range(63) == 0);
      wakeup_request = ($urandom_range(39) == 0);
      wakeup_source  = 4'($urandom_range(15));
      rst            = ($urandom_range(499) == 0);
      if ($urandom_range(99) == 0) begin
        standby_idle_th = 16'($urandom_range(20));
        sleep_idle_th   = 16'($urandom_range(30));
      end
      tick();
    end
    rst = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/power_mode_manager.md
Name: power_mode_manager

Overview:
Upstream stage of clock_gate_controller; generates the registered power_mode[1:0] (00=DeepSleep, 01=Standby, 10=Active) that drives the clock gates.
- Inputs: idle-time counting on module activity signals, software sleep requests, and wakeup_request/wakeup_source from wakeup_controller.
- Sequences safe entry to and exit from DeepSleep using a drain window and a wake ramp window.

Parameters:
IDLE_CNT_W, 16, width of idle counter and threshold inputs
SETTLE_CYCLES, 8, consecutive quiet cycles required in DRAIN before DeepSleep (>=1)
WAKE_CYCLES, 16, cycles spent in WAKE before Active (>=1)

Ports:
clk_master  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
cim_active  in  1  CIM computing
uart_active  in  1  UART busy
dvfs_busy  in  1  DVFS transition in progress
sleep_req  in  1  level; software request for DeepSleep
force_active  in  1  level; override to Active
wakeup_request  in  1  from wakeup_controller
wakeup_source  in  4  {can,timer,uart_rx,gpio}; sampled with wakeup_request
standby_idle_th  in  IDLE_CNT_W  idle cycles Active->Standby; 0 disables
sleep_idle_th  in  IDLE_CNT_W  idle cycles Standby->DeepSleep; 0 disables
power_mode  out  2  registered mode to clock_gate_controller
mode_changed  out  1  one-cycle pulse, coincident with new power_mode value
wake_cause  out  4  latched source of last wake
pm_state  out  3  FSM state for debug
sleep_count  out  16  number of DeepSleep entries (feature)
sleep_cycles  out  32  cycles spent in DeepSleep (feature)

Behaviour:
- Reset (rst=1 at edge): state=ACTIVE, power_mode=10, mode_changed=0, wake_cause=0, idle_cnt=0, all counters 0. Reset mid-operation wins over every other input.
- Activity definitions:
  - activity = cim_active|uart_active|dvfs_busy.
  - idle_cnt increments on each non-activity cycle and saturates at all-ones.
  - idle_cnt clears on activity and on every state change.
- Comparisons use idle_cnt >= threshold (unsigned).
- States (pm_state encoding / power_mode):
  - ACTIVE(0/10):
    - sleep_req -> DRAIN.
    - Else standby_idle_th!=0 && idle_cnt>=standby_idle_th -> STANDBY.
    - wakeup_request ignored.
  - STANDBY(1/01):
    - force_active or cim_active or uart_active -> ACTIVE.
    - Else sleep_req, or (sleep_idle_th!=0 && idle_cnt>=sleep_idle_th) -> DRAIN.
    - dvfs_busy alone keeps STANDBY and resets idle_cnt.
  - DRAIN(2/01):
    - quiet_cnt counts consecutive non-activity cycles and resets on activity.
    - quiet_cnt==SETTLE_CYCLES-1 with no activity -> DEEPSLEEP.
    - wakeup_request or force_active -> ACTIVE (abort; no entry counted).
  - DEEPSLEEP(3/00):
    - wakeup_request -> WAKE, wake_cause<=wakeup_source.
    - force_active -> WAKE, wake_cause<=0.
    - If both occur together, wakeup_request's source is used.
    - sleep_req and activity are ignored.
  - WAKE(4/01):
    - ramp_cnt runs from 0; at ramp_cnt==WAKE_CYCLES-1 -> ACTIVE.
    - All requests are ignored, including sleep_req and wakeup_request.
- Simultaneous-event priority, highest first:
  - rst
  - force_active
  - wakeup_request
  - sleep_req
  - idle thresholds
- Latency: state and power_mode update on the edge after the deciding inputs (1 cycle).
- mode_changed is asserted only when the encoded power_mode value differs from its previous value. Example: STANDBY->DRAIN keeps 01 and produces no pulse.
- Unused state encodings (5-7) -> ACTIVE with mode_changed=1.

Optional Feature:
POWER_MODE_STATS_EN
- Defined:
  - sleep_count increments on each DEEPSLEEP entry and saturates at 0xFFFF.
  - sleep_cycles increments every cycle in DEEPSLEEP and saturates at 0xFFFFFFFF.
  - Both reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops are synthesized.

Decomposition:
- Package power_mode_pkg contains:
  - Mode constants MODE_DEEPSLEEP=2'b00, MODE_STANDBY=2'b01, MODE_ACTIVE=2'b10.
  - pm_state encodings ACTIVE..WAKE.
  - Wakeup source bit indices GPIO=0, UART_RX=1, TIMER=2, CAN=3.
- Sub-module pm_idle_counter: saturating counter with clear/increment and >=threshold compare. Instantiated for idle_cnt; quiet_cnt and ramp_cnt are local counters.

Test Plan:
- Reset with all inputs 0, standby_idle_th=10 -> power_mode=10 after reset; STANDBY (01) plus one mode_changed pulse 11 cycles after reset release.
- In STANDBY, cim_active pulsed 1 cycle -> power_mode=10 the next cycle, mode_changed=1, idle_cnt cleared.
- ACTIVE with sleep_req=1, SETTLE_CYCLES=8, no activity -> DRAIN for 8 cycles, then power_mode=00; sleep_count=1 with POWER_MODE_STATS_EN defined.
- In DRAIN, dvfs_busy high 3 cycles at quiet_cnt=5 -> quiet_cnt restarts; DeepSleep is reached 8 quiet cycles after dvfs_busy falls.
- DEEPSLEEP, wakeup_request=1 with wakeup_source=4'b0100 -> WAKE (01) next cycle, wake_cause=0100; ACTIVE after 16 cycles; sleep_req asserted during WAKE has no effect.
- DRAIN with wakeup_request and sleep_req together -> ACTIVE; rst asserted mid-WAKE -> ACTIVE, counters 0, wake_cause=0 on the next edge.
